// File: rtl/sobel_row_window.sv
// Three-row sliding window feeding the Sobel core; optional stall counter under SOBEL_ROW_WINDOW_STATS_EN.
// Latency: window valid the cycle after the 3rd row load; done pulses one cycle after the strip's last accept.
// Backpressure: srow2smem_ready drops combinationally while a full window waits on sacc2srow_ready.
`ifndef SOBEL_IDATA_WIDTH
`define SOBEL_IDATA_WIDTH 32
`endif

module sobel_row_window #(
    parameter int DATA_W   = `SOBEL_IDATA_WIDTH,
    parameter int ROWCNT_W = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sctrl2srow_restart,
    input  logic [ROWCNT_W-1:0] sctrl2srow_num_rows,
    input  logic [DATA_W-1:0]   smem2srow_data,
    input  logic                smem2srow_valid,
    output logic                srow2smem_ready,
    output logic [DATA_W-1:0]   srow2sacc_row1_data,
    output logic [DATA_W-1:0]   srow2sacc_row2_data,
    output logic [DATA_W-1:0]   srow2sacc_row3_data,
    output logic                srow2sacc_valid,
    input  logic                sacc2srow_ready,
    output logic                srow2sctrl_done
`ifdef SOBEL_ROW_WINDOW_STATS_EN
    ,
    output logic [15:0]         srow2sctrl_stall_cycles
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          r_state;
    logic [1:0]          r_fill;
    logic [ROWCNT_W-1:0] r_cnt;
    logic [ROWCNT_W-1:0] r_num;
    logic [DATA_W-1:0]   r_row1;
    logic [DATA_W-1:0]   r_row2;
    logic [DATA_W-1:0]   r_row3;
    logic                r_done;

    logic w_run;
    logic w_win_vld;
    logic w_ready;
    logic w_load;
    logic w_accept;
    logic w_complete;

    assign w_run     = (r_state == ST_RUN);
    assign w_win_vld = w_run && (r_fill == 2'd3);
    // A full window may be replaced in the same cycle it is consumed.
    assign w_ready   = w_run && (r_cnt < r_num) && !sctrl2srow_restart &&
                       ((r_fill != 2'd3) || sacc2srow_ready);
    assign w_load    = smem2srow_valid && w_ready;
    assign w_accept  = w_win_vld && sacc2srow_ready;
    assign w_complete = w_run && !sctrl2srow_restart && (r_cnt == r_num) &&
                        (w_accept || ((r_fill != 2'd3) && !w_load));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_fill  <= 2'd0;
            r_cnt   <= '0;
            r_num   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (sctrl2srow_restart) begin
                r_state <= ST_RUN;
                r_fill  <= 2'd0;
                r_cnt   <= '0;
                r_num   <= sctrl2srow_num_rows;
            end else begin
                if (w_complete)
                    r_state <= ST_IDLE;
                if (w_load) begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_fill <= (r_fill == 2'd3) ? 2'd3 : r_fill + 2'd1;
                end else if (w_accept) begin
                    r_fill <= 2'd2;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row1 <= '0;
            r_row2 <= '0;
            r_row3 <= '0;
        end else if (w_load) begin
            r_row1 <= r_row2;
            r_row2 <= r_row3;
            r_row3 <= smem2srow_data;
        end
    end

`ifdef SOBEL_ROW_WINDOW_STATS_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_stall <= 16'd0;
        else if (sctrl2srow_restart)
            r_stall <= 16'd0;
        else if (w_win_vld && !sacc2srow_ready && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
    end

    assign srow2sctrl_stall_cycles = r_stall;
`endif

    assign srow2smem_ready     = w_ready;
    assign srow2sacc_valid     = w_win_vld;
    assign srow2sacc_row1_data = r_row1;
    assign srow2sacc_row2_data = r_row2;
    assign srow2sacc_row3_data = r_row3;
    assign srow2sctrl_done     = r_done;

endmodule
